mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares the single 3-cycle handshake multiplier among NREQ requesters (e.g. ALU path, address-calc path).
- Grants the datapath round-robin, drives its cs/A/B and tracks its rdy low→high sequence.
- Captures the 16-bit product and returns it to the granted requester with a one-cycle done pulse.
- Sits between the control unit's requesters and the multiplier; the only block allowed to drive the multiplier's cs.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
TIMEOUT, 8, max cycles allowed in WAIT_LO or WAIT_HI before abort

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester request level
a_in  input  16*NREQ  operand A, requester i at [16i+15:16i]
b_in  input  16*NREQ  operand B, same packing
done  output  NREQ  one-cycle completion pulse to granted requester
err  output  1  one-cycle pulse with done on timeout abort
result_out  output  16  captured product, held until next done
gnt_id  output  2  index of current/last granted requester
busy  output  1  high in any state except IDLE
mul_cs  output  1  multiplier chip select
mul_a  output  16  operand A to multiplier
mul_b  output  16  operand B to multiplier
mul_rdy  input  1  multiplier ready
mul_result  input  16  multiplier product (valid only in its result cycle)

Behaviour:
- Reset (rst_n=0, async): state=SYNC, sync count=0, rr pointer=0, done=0, err=0, result_out=0, gnt_id=0, busy=1, mul_cs=0, mul_a=0, mul_b=0, timeout count=0.
- FSM states: SYNC, IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- SYNC: mul_cs=0 for exactly 2 cycles, then IDLE. The multiplier has no reset; this guarantees it is back in its idle state from any state.
- IDLE (busy=0): if any req bit is set, grant the first set bit searching from the rr pointer upward, with wrap. Register gnt_id and latch that requester's operands into mul_a/mul_b, then go to ISSUE. If no req bit is set, stay in IDLE.
- ISSUE: mul_cs=1 for exactly this one cycle; go to WAIT_LO.
- WAIT_LO: advance to WAIT_HI at the first edge with mul_rdy=0.
- WAIT_HI: at the first edge with mul_rdy=1, capture result_out<=mul_result and go to DONE.
- DONE: done[gnt_id]=1 for one cycle; rr pointer<=(gnt_id+1) mod NREQ; go to IDLE.
- mul_a/mul_b hold their value from the IDLE grant through DONE and keep it afterwards; they are not cleared.
- Nominal latency: req seen at edge E0 → ISSUE. E1 → WAIT_LO (multiplier rdy drops). E2 → WAIT_HI (product valid). E3 → capture, DONE. done is high in the cycle after E3: 4 cycles from req sample to done.
- Back-to-back throughput: one product per 5 cycles.
- Sampling: all datapath inputs are sampled with nonblocking registers at the edge. The multiplier product is valid for the whole E2–E3 cycle and is captured at E3.
- Timeout: a counter resets on entry to WAIT_LO and WAIT_HI. If it reaches TIMEOUT while waiting, go to DONE with err=1 and result_out=0.
- Requester rules:
  - req must stay high and operands stable until done.
  - Dropping req before done does not abort the operation; done still pulses and is ignored.
  - req still high after done is a new request, re-arbitrated behind the other requesters.
- Simultaneous requests: only one grant. The loser waits; it is granted next because the pointer moves past the winner.
- Requests arriving while busy are held pending (level) and are not lost.
- Reset mid-operation: every output returns to its reset value immediately, and the in-flight result is discarded with no done pulse. Operation resumes via SYNC.
- Width: the 16-bit operands are forwarded unmodified; product width and truncation are the datapath's responsibility.

Test Plan:
- Single request: rst_n release, then req=01 with a_in[15:0]=0x0012, b_in[15:0]=0x0034. After SYNC, mul_cs pulses one cycle; done=01 four cycles after req is sampled; result_out=0x03A8; err=0; gnt_id=0.
- Simultaneous requests: req=11, operands r0 0x0003×0x0005, r1 0x0007×0x0009, both held. r0 gets done with 0x000F; r1 gets done 5 cycles later with 0x003F; rr pointer=0 after r1.
- Fairness: req=11 held continuously for 6 operations. Grants strictly alternate 0,1,0,1,0,1; no requester is granted twice in a row.
- Timeout: multiplier model with mul_rdy stuck at 1 and req=10. After ISSUE, TIMEOUT=8 cycles elapse in WAIT_LO, then done=10, err=1, result_out=0x0000, and FSM returns to IDLE.
- Reset mid-op: assert rst_n=0 during WAIT_HI. Outputs go to reset values the same instant; no done pulse; 2 SYNC cycles follow; a re-issued req=01 of 0x00FF×0x00FF completes with 0xFE01.
- Operand hold: change a_in for r0 during WAIT_LO. mul_a stays at the value latched at grant, and result_out reflects the original operands.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one 3-cycle handshake multiplier among NREQ requesters.
// Requests are granted round-robin. The grantee's operands are latched and
// driven to the multiplier, which is started with a one-cycle cs pulse. The
// block then follows the multiplier's rdy low->high sequence, captures the
// product and returns it with a one-cycle done pulse. A wait that runs for
// TIMEOUT cycles aborts the operation and flags err. After reset, cs is held
// low for two cycles so that the multiplier, which has no reset, can settle
// back to idle.
module mul_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   a_in,
    input  logic [16*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [15:0]          result_out,
    output logic [1:0]           gnt_id,
    output logic                 busy,
    output logic                 mul_cs,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic                 mul_rdy,
    input  logic [15:0]          mul_result
);

    localparam logic [2:0] SYNC    = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] ISSUE   = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    logic [2:0]      state_r;
    logic            sync_cnt_r;
    logic [1:0]      rr_r;
    logic [TW-1:0]   tcnt_r;
    logic [NREQ-1:0] done_r;
    logic            err_r;
    logic [15:0]     result_r;
    logic [1:0]      gnt_id_r;
    logic            busy_r;
    logic            mul_cs_r;
    logic [15:0]     mul_a_r;
    logic [15:0]     mul_b_r;

    logic            found_hi_s;
    logic            found_lo_s;
    logic [1:0]      sel_hi_s;
    logic [1:0]      sel_lo_s;
    logic            found_s;
    logic [1:0]      sel_s;
    logic [15:0]     a_sel_s;
    logic [15:0]     b_sel_s;
    logic [1:0]      rr_next_s;

    // One-hot decode of a requester index into a done vector.
    function automatic logic [NREQ-1:0] id_onehot(input logic [1:0] id);
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (id == 2'(i));
        end
        return oh;
    endfunction

    // Round-robin pick: first request at or above the pointer, else the lowest one (wrap).
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        sel_hi_s   = 2'd0;
        sel_lo_s   = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_hi_s && req[i] && (2'(i) >= rr_r)) begin
                found_hi_s = 1'b1;
                sel_hi_s   = 2'(i);
            end else begin
                found_hi_s = found_hi_s;
            end
            if (!found_lo_s && req[i]) begin
                found_lo_s = 1'b1;
                sel_lo_s   = 2'(i);
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        found_s = found_hi_s | found_lo_s;
        if (found_hi_s) begin
            sel_s = sel_hi_s;
        end else begin
            sel_s = sel_lo_s;
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        a_sel_s = 16'h0000;
        b_sel_s = 16'h0000;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_s == 2'(i)) begin
                a_sel_s = a_in[16*i +: 16];
                b_sel_s = b_in[16*i +: 16];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        if (gnt_id_r == 2'(NREQ - 1)) begin
            rr_next_s = 2'd0;
        end else begin
            rr_next_s = gnt_id_r + 2'd1;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SYNC;
            sync_cnt_r <= 1'b0;
            rr_r       <= 2'd0;
            tcnt_r     <= {TW{1'b0}};
            done_r     <= {NREQ{1'b0}};
            err_r      <= 1'b0;
            result_r   <= 16'h0000;
            gnt_id_r   <= 2'd0;
            busy_r     <= 1'b1;
            mul_cs_r   <= 1'b0;
            mul_a_r    <= 16'h0000;
            mul_b_r    <= 16'h0000;
        end else begin
            done_r <= {NREQ{1'b0}};
            err_r  <= 1'b0;
            case (state_r)
                SYNC: begin
                    mul_cs_r <= 1'b0;
                    if (sync_cnt_r) begin
                        sync_cnt_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        sync_cnt_r <= 1'b1;
                    end
                end
                IDLE: begin
                    if (found_s) begin
                        gnt_id_r <= sel_s;
                        mul_a_r  <= a_sel_s;
                        mul_b_r  <= b_sel_s;
                        mul_cs_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ISSUE: begin
                    mul_cs_r <= 1'b0;
                    tcnt_r   <= {TW{1'b0}};
                    state_r  <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!mul_rdy) begin
                        tcnt_r  <= {TW{1'b0}};
                        state_r <= WAIT_HI;
                    end else if (tcnt_r == TCNT_LAST) begin
                        done_r   <= id_onehot(gnt_id_r);
                        err_r    <= 1'b1;
                        result_r <= 16'h0000;
                        state_r  <= DONE;
                    end else begin
                        tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                WAIT_HI: begin
                    if (mul_rdy) begin
                        done_r   <= id_onehot(gnt_id_r);
                        result_r <= mul_result;
                        state_r  <= DONE;
                    end else if (tcnt_r == TCNT_LAST) begin
                        done_r   <= id_onehot(gnt_id_r);
                        err_r    <= 1'b1;
                        result_r <= 16'h0000;
                        state_r  <= DONE;
                    end else begin
                        tcnt_r <= tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    rr_r    <= rr_next_s;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mul_cs_r   <= 1'b0;
                    sync_cnt_r <= 1'b0;
                    busy_r     <= 1'b1;
                    state_r    <= SYNC;
                end
            endcase
        end
    end

    assign done       = done_r;
    assign err        = err_r;
    assign result_out = result_r;
    assign gnt_id     = gnt_id_r;
    assign busy       = busy_r;
    assign mul_cs     = mul_cs_r;
    assign mul_a      = mul_a_r;
    assign mul_b      = mul_b_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter: a behavioural 3-cycle multiplier, a table of
// single-request vectors, hand-written corner sequences and randomized rounds
// scored against a queue-based round-robin reference.
module tb_mul_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  a_in;
    logic [16*NREQ-1:0]  b_in;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [15:0]         result_out;
    logic [1:0]          gnt_id;
    logic                busy;
    logic                mul_cs;
    logic [15:0]         mul_a;
    logic [15:0]         mul_b;
    logic                mul_rdy = 1'b1;
    logic [15:0]         mul_result = 16'hDEAD;

    logic                stuck = 1'b0;
    int                  mphase = 0;
    logic [31:0]         mul_prod;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .done       (done),
        .err        (err),
        .result_out (result_out),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .mul_cs     (mul_cs),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rdy    (mul_rdy),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    assign mul_prod = 32'(mul_a) * 32'(mul_b);

    // Multiplier model: cs seen -> rdy low for one cycle -> rdy high with product for one cycle.
    always @(posedge clk) begin
        if (stuck) begin
            mul_rdy    <= 1'b1;
            mul_result <= 16'hDEAD;
            mphase     <= 0;
        end else begin
            case (mphase)
                0: begin
                    mul_result <= 16'hDEAD;
                    if (mul_cs) begin
                        mul_rdy <= 1'b0;
                        mphase  <= 1;
                    end else begin
                        mul_rdy <= 1'b1;
                    end
                end
                1: begin
                    mul_rdy    <= 1'b1;
                    mul_result <= mul_prod[15:0];
                    mphase     <= 2;
                end
                default: begin
                    mul_rdy    <= 1'b1;
                    mul_result <= 16'hDEAD;
                    mphase     <= 0;
                end
            endcase
        end
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a done pulse, counting cycles and sampled mul_cs cycles.
    task automatic wait_done(output int cyc, output int cs_cnt);
        cyc = 0;
        cs_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (mul_cs) cs_cnt++;
            if (done != '0) break;
        end
    endtask

    task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] exp);
        int cyc;
        int cs_cnt;
        logic [15:0] held;
        a_in[16*id +: 16] = a;
        b_in[16*id +: 16] = b;
        req = oh(id);
        wait_done(cyc, cs_cnt);
        check("single_latency", 32'(cyc), 32'd4);
        check("single_cs_pulses", 32'(cs_cnt), 32'd1);
        check("single_done", 32'(done), 32'(oh(id)));
        check("single_result", 32'(result_out), 32'(exp));
        check("single_err", 32'(err), 32'd0);
        check("single_gnt", 32'(gnt_id), 32'(id));
        held = exp;
        req = '0;
        @(negedge clk);
        check("single_done_clear", 32'(done), 32'd0);
        check("single_result_held", 32'(result_out), 32'(held));
    endtask

    // Release reset and confirm two SYNC cycles with cs low before IDLE.
    task automatic release_and_sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("sync1_busy", 32'(busy), 32'd1);
        check("sync1_cs", 32'(mul_cs), 32'd0);
        @(negedge clk);
        check("sync2_busy", 32'(busy), 32'd0);
        check("sync2_cs", 32'(mul_cs), 32'd0);
    endtask

    int cyc;
    int cs_cnt;
    int p;
    int idx;
    int exp_q[$];
    logic [15:0] aop[NREQ];
    logic [15:0] bop[NREQ];
    logic [31:0] prod;
    logic [NREQ-1:0] mask;
    int first;
    int done_seen;

    initial begin
        vecs[0] = '{0, 16'h0012, 16'h0034, 16'h03A8};
        vecs[1] = '{1, 16'h0007, 16'h0009, 16'h003F};
        vecs[2] = '{0, 16'h00FF, 16'h00FF, 16'hFE01};
        vecs[3] = '{1, 16'h0100, 16'h0100, 16'h0000};
        vecs[4] = '{0, 16'h1234, 16'h0000, 16'h0000};
        vecs[5] = '{0, 16'h0003, 16'h0005, 16'h000F};
        vecs[6] = '{1, 16'hFFFF, 16'h0002, 16'hFFFE};

        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cs", 32'(mul_cs), 32'd0);
        check("rst_result", 32'(result_out), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        release_and_sync();

        // Table of single requests; last entry is requester 1, leaving the pointer at 0.
        for (int i = 0; i < 7; i++) begin
            run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Simultaneous requests held for 6 operations: strict alternation from requester 0.
        a_in = {16'h0007, 16'h0003};
        b_in = {16'h0009, 16'h0005};
        req  = 2'b11;
        for (int n = 0; n < 6; n++) begin
            wait_done(cyc, cs_cnt);
            check("fair_latency", 32'(cyc), (n == 0) ? 32'd4 : 32'd5);
            check("fair_done", 32'(done), 32'(oh(n % 2)));
            check("fair_gnt", 32'(gnt_id), 32'(n % 2));
            check("fair_result", 32'(result_out), (n % 2 == 0) ? 32'h000F : 32'h003F);
        end
        req = '0;
        @(negedge clk);

        // Timeout: rdy stuck high, requester 1.
        stuck = 1'b1;
        a_in[31:16] = 16'h0004;
        b_in[31:16] = 16'h0004;
        req = 2'b10;
        wait_done(cyc, cs_cnt);
        req = '0;
        check("to_latency", 32'(cyc), 32'(TIMEOUT + 2));
        check("to_done", 32'(done), 32'b10);
        check("to_err", 32'(err), 32'd1);
        check("to_result", 32'(result_out), 32'd0);
        @(negedge clk);
        check("to_err_clear", 32'(err), 32'd0);
        check("to_done_clear", 32'(done), 32'd0);
        @(negedge clk);
        check("to_idle", 32'(busy), 32'd0);
        stuck = 1'b0;
        @(negedge clk);

        // Normal op to leave a nonzero result, then reset during WAIT_HI of requester 1.
        run_single(1, 16'h0007, 16'h0009, 16'h003F);
        a_in[31:16] = 16'h0003;
        b_in[31:16] = 16'h0005;
        req = 2'b10;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_result", 32'(result_out), 32'd0);
        check("mid_gnt", 32'(gnt_id), 32'd0);
        check("mid_cs", 32'(mul_cs), 32'd0);
        check("mid_mul_a", 32'(mul_a), 32'd0);
        check("mid_mul_b", 32'(mul_b), 32'd0);
        req = '0;
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done != '0) done_seen++;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        release_and_sync();
        run_single(0, 16'h00FF, 16'h00FF, 16'hFE01);

        // Operand change during WAIT_LO must not affect the running operation.
        a_in[15:0] = 16'h0011;
        b_in[15:0] = 16'h0002;
        req = 2'b01;
        repeat (2) @(negedge clk);
        a_in[15:0] = 16'h00AA;
        @(negedge clk);
        check("hold_mul_a", 32'(mul_a), 32'h0011);
        wait_done(cyc, cs_cnt);
        check("hold_latency", 32'(cyc + 3), 32'd4);
        check("hold_result", 32'(result_out), 32'h0022);
        req = '0;
        @(negedge clk);

        // Randomized rounds vs. a round-robin service-order model; pointer is 1 here.
        p = 1;
        for (int r = 0; r < 20; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                aop[i] = 16'($urandom);
                bop[i] = 16'($urandom);
                a_in[16*i +: 16] = aop[i];
                b_in[16*i +: 16] = bop[i];
            end
            exp_q.delete();
            for (int k = 0; k < NREQ; k++) begin
                idx = (p + k) % NREQ;
                if (mask[idx]) exp_q.push_back(idx);
            end
            req = mask;
            first = 1;
            while (exp_q.size() > 0) begin
                wait_done(cyc, cs_cnt);
                idx = exp_q.pop_front();
                prod = 32'(aop[idx]) * 32'(bop[idx]);
                check("rnd_latency", 32'(cyc), first ? 32'd4 : 32'd5);
                check("rnd_done", 32'(done), 32'(oh(idx)));
                check("rnd_gnt", 32'(gnt_id), 32'(idx));
                check("rnd_result", 32'(result_out), {16'h0000, prod[15:0]});
                check("rnd_err", 32'(err), 32'd0);
                req[idx] = 1'b0;
                p = (idx + 1) % NREQ;
                first = 0;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
